// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, fail causes
// and the per-write classification produced by wrchk_match.
package mem_write_checker_pkg;

  localparam int FAIL_CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_e;

  typedef enum logic [FAIL_CODE_W-1:0] {
    NONE          = 3'd0,
    UNEXP_ADDR    = 3'd1,
    DATA_MISMATCH = 3'd2,
    ORDER         = 3'd3,
    TIMEOUT       = 3'd4
  } fail_code_e;

  typedef enum logic [2:0] {
    CLS_MATCH,
    CLS_IGNORE,
    CLS_ORDER,
    CLS_DATA,
    CLS_UNEXP
  } wr_class_e;

  function automatic fail_code_e codeOf(input wr_class_e cls);
    case (cls)
      CLS_ORDER: return ORDER;
      CLS_DATA:  return DATA_MISMATCH;
      CLS_UNEXP: return UNEXP_ADDR;
      default:   return NONE;
    endcase
  endfunction

endpackage

// File: rtl/wrchk_match.sv
// Combinational classifier: decides how one monitored write relates to the
// expected-write table (match / ignore / order / data / unexpected).
module wrchk_match
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int ORDERED = 1,
  parameter int IDX_W   = 2
) (
  input  logic [ADDR_W-1:0]         wrAddr,
  input  logic [DATA_W-1:0]         wrData,
  input  logic [NUM_EXP*ADDR_W-1:0] expAddr,
  input  logic [NUM_EXP*DATA_W-1:0] expData,
  input  logic [NUM_EXP-1:0]        matched,
  input  logic [IDX_W-1:0]          idx,
  input  logic [ADDR_W-1:0]         ignLo,
  input  logic [ADDR_W-1:0]         ignHi,
  output wr_class_e                 wrClass,
  output logic [IDX_W-1:0]          matchIdx
);

  logic [NUM_EXP-1:0] addrEq;
  logic [NUM_EXP-1:0] fullEq;
  logic hitMatch, hitOrder, hitData, hitRehit, inWindow;

  for (genvar k = 0; k < NUM_EXP; k++) begin : g_cmp
    assign addrEq[k] = (expAddr[k*ADDR_W +: ADDR_W] == wrAddr);
    assign fullEq[k] = addrEq[k] && (expData[k*DATA_W +: DATA_W] == wrData);
  end

  // An inverted window (lo > hi) naturally contains no address.
  assign inWindow = (wrAddr >= ignLo) && (wrAddr <= ignHi);

  always_comb begin
    hitMatch = 1'b0;
    hitOrder = 1'b0;
    hitData  = 1'b0;
    hitRehit = 1'b0;
    matchIdx = '0;
    for (int unsigned k = 0; k < NUM_EXP; k++) begin
      if (ORDERED != 0) begin
        if ((IDX_W'(k) == idx) && fullEq[k]) begin
          hitMatch = 1'b1;
          matchIdx = IDX_W'(k);
        end else if ((IDX_W'(k) > idx) && !matched[k] && fullEq[k]) begin
          hitOrder = 1'b1;
        end
      end else begin
        if (!matched[k] && fullEq[k] && !hitMatch) begin
          hitMatch = 1'b1;
          matchIdx = IDX_W'(k);
        end
        if (matched[k] && fullEq[k]) hitRehit = 1'b1;
      end
      if (!matched[k] && addrEq[k] && !fullEq[k]) hitData = 1'b1;
    end
  end

  always_comb begin
    wrClass = CLS_UNEXP;
    if (hitMatch)                  wrClass = CLS_MATCH;
    else if (inWindow || hitRehit) wrClass = CLS_IGNORE;
    else if (hitOrder)             wrClass = CLS_ORDER;
    else if (hitData)              wrClass = CLS_DATA;
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the core's data-memory write port with registered
// pass/fail/timeout verdict. MEM_WRITE_CHECKER_HISTORY_EN adds a 4-deep write history.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int ORDERED     = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_mem_write,
  input  logic [ADDR_W-1:0]         i_data_adr,
  input  logic [DATA_W-1:0]         i_write_data,
  input  logic [NUM_EXP*ADDR_W-1:0] i_exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] i_exp_data,
  input  logic [ADDR_W-1:0]         i_ign_lo,
  input  logic [ADDR_W-1:0]         i_ign_hi,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [FAIL_CODE_W-1:0]    o_fail_code,
  output logic [ADDR_W-1:0]         o_fail_addr,
  output logic [DATA_W-1:0]         o_fail_data,
  output logic [CNT_W-1:0]          o_match_cnt,
  output logic [CNT_W-1:0]          o_ign_cnt,
  output logic [ADDR_W-1:0]         o_hist_addr,
  output logic [DATA_W-1:0]         o_hist_data,
  input  logic [1:0]                i_hist_sel
);

  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state;
  logic [NUM_EXP-1:0] matched;
  logic [NUM_EXP-1:0] matchOneHot;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   matchIdx;
  logic [TMR_W-1:0]   cycCnt;
  wr_class_e          wrClass;
  logic               wrValid, allMatched, wrPass, wrFail, timeoutHit;

  wrchk_match #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP),
    .ORDERED(ORDERED),
    .IDX_W  (IDX_W)
  ) u_match (
    .wrAddr  (i_data_adr),
    .wrData  (i_write_data),
    .expAddr (i_exp_addr),
    .expData (i_exp_data),
    .matched (matched),
    .idx     (idx),
    .ignLo   (i_ign_lo),
    .ignHi   (i_ign_hi),
    .wrClass (wrClass),
    .matchIdx(matchIdx)
  );

  assign wrValid     = (state == RUN) && i_mem_write;
  assign matchOneHot = NUM_EXP'(1) << matchIdx;
  // Completion comes from the bitmap, not o_match_cnt, which may saturate.
  assign allMatched  = &(matched | matchOneHot);
  assign wrPass      = wrValid && (wrClass == CLS_MATCH) && allMatched;
  assign wrFail      = wrValid && (wrClass inside {CLS_ORDER, CLS_DATA, CLS_UNEXP});
  assign timeoutHit  = (TIMEOUT_CYC != 0) && (state == RUN) &&
                       (cycCnt == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_code <= '0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_match_cnt <= '0;
      o_ign_cnt   <= '0;
      matched     <= '0;
      idx         <= '0;
      cycCnt      <= '0;
    end else if (i_start) begin
      state       <= RUN;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_code <= '0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_match_cnt <= '0;
      o_ign_cnt   <= '0;
      matched     <= '0;
      idx         <= '0;
      cycCnt      <= '0;
    end else if (state == RUN) begin
      if (wrValid && (wrClass == CLS_MATCH)) begin
        matched <= matched | matchOneHot;
        idx     <= idx + 1'b1;
        if (~&o_match_cnt) o_match_cnt <= o_match_cnt + 1'b1;
      end
      if (wrValid && (wrClass == CLS_IGNORE) && ~&o_ign_cnt) o_ign_cnt <= o_ign_cnt + 1'b1;
      if (TIMEOUT_CYC != 0) cycCnt <= cycCnt + 1'b1;

      // A completing match beats a same-cycle timeout.
      if (wrPass) begin
        state  <= PASS;
        o_busy <= 1'b0;
        o_done <= 1'b1;
        o_pass <= 1'b1;
      end else if (wrFail) begin
        state       <= FAIL;
        o_busy      <= 1'b0;
        o_done      <= 1'b1;
        o_fail_code <= codeOf(wrClass);
        o_fail_addr <= i_data_adr;
        o_fail_data <= i_write_data;
      end else if (timeoutHit) begin
        state       <= FAIL;
        o_busy      <= 1'b0;
        o_done      <= 1'b1;
        o_fail_code <= TIMEOUT;
        o_fail_addr <= '0;
        o_fail_data <= '0;
      end
    end
  end

`ifdef MEM_WRITE_CHECKER_HISTORY_EN
  logic [ADDR_W-1:0] histAddr [4];
  logic [DATA_W-1:0] histData [4];
  logic [1:0]        histPtr;
  logic [1:0]        histRd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || i_start) begin
      histPtr <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        histAddr[k] <= '0;
        histData[k] <= '0;
      end
    end else if (wrValid) begin
      histAddr[histPtr] <= i_data_adr;
      histData[histPtr] <= i_write_data;
      histPtr           <= histPtr + 2'd1;
    end
  end

  // histPtr points at the next free slot, so the newest entry is one behind it.
  assign histRd      = histPtr - 2'd1 - i_hist_sel;
  assign o_hist_addr = histAddr[histRd];
  assign o_hist_data = histData[histRd];
`else
  logic unusedHistSel;
  assign unusedHistSel = ^i_hist_sel;
  assign o_hist_addr   = '0;
  assign o_hist_data   = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: three checker instances (1-entry ordered, 2-entry ordered,
// 2-entry unordered with 2-bit counters) share one write stream.
module tb_mem_write_checker;
  import mem_write_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, memWrite;
  logic [31:0] adr, wdata, ignLo, ignHi;
  logic [1:0]  histSel;

  logic [31:0] expAddrA, expDataA;
  logic [63:0] expAddrB, expDataB;

  logic        aBusy, aDone, aPass;
  logic [2:0]  aCode;
  logic [31:0] aFailAddr, aFailData, aHistAddr, aHistData;
  logic [15:0] aMatch, aIgn;

  logic        bBusy, bDone, bPass;
  logic [2:0]  bCode;
  logic [31:0] bFailAddr, bFailData, bHistAddr, bHistData;
  logic [15:0] bMatch, bIgn;

  logic        cBusy, cDone, cPass;
  logic [2:0]  cCode;
  logic [31:0] cFailAddr, cFailData, cHistAddr, cHistData;
  logic [1:0]  cMatch, cIgn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(1), .ORDERED(1), .TIMEOUT_CYC(16), .CNT_W(16)) dutA (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mem_write(memWrite),
    .i_data_adr(adr), .i_write_data(wdata), .i_exp_addr(expAddrA), .i_exp_data(expDataA),
    .i_ign_lo(ignLo), .i_ign_hi(ignHi), .o_busy(aBusy), .o_done(aDone), .o_pass(aPass),
    .o_fail_code(aCode), .o_fail_addr(aFailAddr), .o_fail_data(aFailData),
    .o_match_cnt(aMatch), .o_ign_cnt(aIgn), .o_hist_addr(aHistAddr), .o_hist_data(aHistData),
    .i_hist_sel(histSel));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(1), .TIMEOUT_CYC(1024), .CNT_W(16)) dutB (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mem_write(memWrite),
    .i_data_adr(adr), .i_write_data(wdata), .i_exp_addr(expAddrB), .i_exp_data(expDataB),
    .i_ign_lo(ignLo), .i_ign_hi(ignHi), .o_busy(bBusy), .o_done(bDone), .o_pass(bPass),
    .o_fail_code(bCode), .o_fail_addr(bFailAddr), .o_fail_data(bFailData),
    .o_match_cnt(bMatch), .o_ign_cnt(bIgn), .o_hist_addr(bHistAddr), .o_hist_data(bHistData),
    .i_hist_sel(histSel));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(0), .TIMEOUT_CYC(1024), .CNT_W(2)) dutC (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mem_write(memWrite),
    .i_data_adr(adr), .i_write_data(wdata), .i_exp_addr(expAddrB), .i_exp_data(expDataB),
    .i_ign_lo(ignLo), .i_ign_hi(ignHi), .o_busy(cBusy), .o_done(cDone), .o_pass(cPass),
    .o_fail_code(cCode), .o_fail_addr(cFailAddr), .o_fail_data(cFailData),
    .o_match_cnt(cMatch), .o_ign_cnt(cIgn), .o_hist_addr(cHistAddr), .o_hist_data(cHistData),
    .i_hist_sel(histSel));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1;
    adr      = a;
    wdata    = d;
    @(negedge clk);
    memWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; memWrite = 1'b0; adr = '0; wdata = '0;
    ignLo = 32'd96; ignHi = 32'd96; histSel = 2'd0;
    expAddrA = 32'd100; expDataA = 32'd25;
    expAddrB = {32'd104, 32'd100};
    expDataB = {32'd9,   32'd25};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", aBusy, 0);
    chk("rst_done", aDone, 0);
    chk("rst_code", aCode, 0);
    chk("rst_match", bMatch, 0);
    rst = 1'b0;

    // Strobe in IDLE is ignored
    wr(32'd100, 32'd25);
    chk("idle_match", aMatch, 0);
    chk("idle_busy", aBusy, 0);

    // Ignore then match on single-entry table, one-cycle verdict latency
    pulseStart();
    chk("start_busy", aBusy, 1);
    wr(32'd96, 32'd7);
    chk("ign_cnt", aIgn, 1);
    chk("ign_notdone", aDone, 0);
    wr(32'd100, 32'd25);
    chk("pass_done", aDone, 1);
    chk("pass_pass", aPass, 1);
    chk("pass_match", aMatch, 1);
    chk("pass_code", aCode, 0);
    chk("pass_busy", aBusy, 0);
    chk("b_partial_match", bMatch, 1);
    chk("b_partial_busy", bBusy, 1);
    wr(32'd100, 32'd25);
    chk("pass_hold_match", aMatch, 1);

    // Unexpected address; later good write changes nothing
    pulseStart();
    wr(32'd104, 32'd25);
    chk("unexp_code", aCode, 1);
    chk("unexp_addr", aFailAddr, 104);
    chk("unexp_data", aFailData, 25);
    chk("unexp_pass", aPass, 0);
    chk("b_dmis_code", bCode, 2);
    wr(32'd100, 32'd25);
    chk("unexp_hold_code", aCode, 1);
    chk("unexp_hold_match", aMatch, 0);
    chk("unexp_hold_addr", aFailAddr, 104);

    // Data mismatch
    pulseStart();
    chk("restart_code", aCode, 0);
    wr(32'd100, 32'd26);
    chk("dmis_code", aCode, 2);
    chk("dmis_data", aFailData, 26);
    chk("dmis_addr", aFailAddr, 100);

    // Out of order: ordered fails, unordered passes
    pulseStart();
    wr(32'd104, 32'd9);
    chk("ord_code", bCode, 3);
    chk("ord_done", bDone, 1);
    chk("unord_busy", cBusy, 1);
    wr(32'd100, 32'd25);
    chk("unord_pass", cPass, 1);
    chk("unord_match", cMatch, 2);
    chk("ord_hold_code", bCode, 3);

    // Re-hit tolerance (unordered) and counter saturation at 2 bits
    pulseStart();
    wr(32'd100, 32'd25);
    wr(32'd100, 32'd25);
    chk("rehit_ign", cIgn, 1);
    chk("rehit_ordered_unexp", bCode, 1);
    wr(32'd96, 32'd1);
    wr(32'd96, 32'd2);
    wr(32'd96, 32'd3);
    chk("sat_ign", cIgn, 3);
    chk("sat_match", cMatch, 1);
    chk("sat_busy", cBusy, 1);

    // Empty window: lo > hi ignores nothing
    ignLo = 32'd200; ignHi = 32'd100;
    pulseStart();
    wr(32'd150, 32'd0);
    chk("empty_win_code", aCode, 1);
    ignLo = 32'd96; ignHi = 32'd96;

    // Timeout after exactly 16 edges
    pulseStart();
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", aDone, 0);
    @(negedge clk);
    chk("tmo_done", aDone, 1);
    chk("tmo_code", aCode, 4);
    chk("tmo_addr", aFailAddr, 0);
    chk("tmo_data", aFailData, 0);

    // Final match on the timeout cycle wins
    pulseStart();
    repeat (15) @(negedge clk);
    wr(32'd100, 32'd25);
    chk("tmo_race_pass", aPass, 1);
    chk("tmo_race_code", aCode, 0);

    // Asynchronous reset mid-RUN, then a clean run
    pulseStart();
    wr(32'd100, 32'd25);
    chk("pre_rst_match", bMatch, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bBusy, 0);
    chk("arst_match", bMatch, 0);
    chk("arst_a_done", aDone, 0);
    chk("arst_a_pass", aPass, 0);
    @(negedge clk);
    rst = 1'b0;
    pulseStart();
    wr(32'd100, 32'd25);
    wr(32'd104, 32'd9);
    chk("post_rst_pass", bPass, 1);
    chk("post_rst_match", bMatch, 2);

`ifdef MEM_WRITE_CHECKER_HISTORY_EN
    histSel = 2'd0;
    #1;
    chk("hist0_addr", bHistAddr, 104);
    chk("hist0_data", bHistData, 9);
    histSel = 2'd1;
    #1;
    chk("hist1_addr", bHistAddr, 100);
    chk("hist1_data", bHistData, 25);
    histSel = 2'd2;
    #1;
    chk("hist2_addr", bHistAddr, 0);
`else
    chk("hist_tied_addr", bHistAddr, 0);
    chk("hist_tied_data", bHistData, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
